// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: sequencer in front of the motor PWM stage.
// Accepts speed/direction commands over valid/ready, ramps duty in fixed
// steps at a prescaled tick rate, and on a direction change ramps to zero,
// holds a dead time, flips dir, then ramps back up.
//
// Optional watchdog: define MOTOR_RAMP_WDT_EN to enable it.
//
// Ports:
//   cin        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted (IDLE/RUN)
//   cmd_en     in   1 = run, 0 = stop
//   cmd_dir    in   1 = forward, 0 = backward
//   cmd_duty   in   target duty
//   duty_cycle out  duty to PWM block
//   dir        out  direction to PWM block
//   enable     out  PWM enable
//   busy       out  state != IDLE
//   at_target  out  duty/dir match the effective target, no reversal pending
//   wdt_trip   out  watchdog fired (sticky until next accepted command)
//
// state    | meaning
// IDLE     | stopped, duty 0, waiting for a non-zero run command
// RUN      | ramping towards the effective target
// REV_DOWN | reversal requested, ramping duty to zero
// DEAD     | zero duty held for DEAD_TICKS ticks before dir flips
module motor_ramp_ctrl #(
    parameter int unsigned RAMP_DIV   = 1000,
    parameter int unsigned RAMP_STEP  = 4,
    parameter int unsigned DEAD_TICKS = 8,
    parameter int unsigned PRESC_W    = 16,
    parameter int unsigned WDT_TICKS  = 256
) (
    input  logic       cin,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_en,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_duty,
    output logic [7:0] duty_cycle,
    output logic       dir,
    output logic       enable,
    output logic       busy,
    output logic       at_target,
    output logic       wdt_trip
);

    localparam int unsigned DEAD_W = (DEAD_TICKS < 2) ? 1 : $clog2(DEAD_TICKS + 1);
    localparam logic [8:0]  STEP9  = 9'(RAMP_STEP);

    typedef enum logic [1:0] {IDLE, RUN, REV_DOWN, DEAD} state_t;

    state_t              state_q, state_d;
    logic [7:0]          duty_q, duty_d;
    logic                dir_q, dir_d;
    logic                enable_q, enable_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                at_tgt_q, at_tgt_d;
    logic [7:0]          tgt_duty_q, tgt_duty_d;
    logic                tgt_dir_q, tgt_dir_d;
    logic                tgt_en_q, tgt_en_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;

    logic                tick, accept;
    logic [7:0]          eff, eff_d;
    logic [8:0]          up9;
    logic [7:0]          dn0, ramp_to_eff;

    assign tick   = (presc_q == PRESC_W'(RAMP_DIV - 1));
    assign accept = cmd_valid & ready_q;
    assign eff    = tgt_en_q ? tgt_duty_q : 8'd0;

    // Steps are computed 9 bits wide and clamped so duty never wraps.
    assign up9 = {1'b0, duty_q} + STEP9;
    assign dn0 = ({1'b0, duty_q} > STEP9) ? (duty_q - STEP9[7:0]) : 8'd0;

    always_comb begin
        ramp_to_eff = duty_q;
        if (duty_q < eff)
            ramp_to_eff = (up9 > {1'b0, eff}) ? eff : up9[7:0];
        else if (duty_q > eff)
            ramp_to_eff = (dn0 < eff) ? eff : dn0;
    end

`ifdef MOTOR_RAMP_WDT_EN
    localparam int unsigned WDT_W = (WDT_TICKS < 2) ? 1 : $clog2(WDT_TICKS + 1);
    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             wdt_trip_q, wdt_trip_d;
`endif

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        dir_d      = dir_q;
        dead_d     = dead_q;
        tgt_duty_d = tgt_duty_q;
        tgt_dir_d  = tgt_dir_q;
        tgt_en_d   = tgt_en_q;
        presc_d    = tick ? '0 : presc_q + PRESC_W'(1);

        if (accept) begin
            tgt_duty_d = cmd_duty;
            tgt_dir_d  = cmd_dir;
            tgt_en_d   = cmd_en;
        end

`ifdef MOTOR_RAMP_WDT_EN
        wdt_cnt_d  = wdt_cnt_q;
        wdt_trip_d = wdt_trip_q;
        if (accept) begin
            wdt_cnt_d  = '0;
            wdt_trip_d = 1'b0;
        end else begin
            if (tick && state_q != IDLE && wdt_cnt_q != WDT_W'(WDT_TICKS))
                wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
            // Forcing the run flag off makes the normal ramp logic bring
            // the motor down to a stop.
            if (wdt_cnt_d == WDT_W'(WDT_TICKS)) begin
                wdt_trip_d = 1'b1;
                tgt_en_d   = 1'b0;
            end
        end
`endif

        // The FSM works on the registered target, so an accept only
        // affects behaviour from the following cycle.
        unique case (state_q)
            IDLE: begin
                duty_d = 8'd0;
                if (eff != 8'd0) begin
                    state_d = RUN;
                    dir_d   = tgt_dir_q;
                end
            end
            RUN: begin
                if (duty_q == 8'd0 && eff == 8'd0) begin
                    state_d = IDLE;
                end else if (tgt_dir_q != dir_q) begin
                    if (duty_q != 8'd0) begin
                        state_d = REV_DOWN;
                        if (tick) duty_d = dn0;
                    end else begin
                        // No current flowing: flip immediately, no dead time.
                        dir_d = tgt_dir_q;
                        if (tick) duty_d = ramp_to_eff;
                    end
                end else if (tick) begin
                    duty_d = ramp_to_eff;
                end
            end
            REV_DOWN: begin
                if (tick) duty_d = dn0;
                if (duty_d == 8'd0) begin
                    state_d = DEAD;
                    dead_d  = DEAD_W'(DEAD_TICKS);
                end
            end
            DEAD: begin
                duty_d = 8'd0;
                if (dead_q == '0) begin
                    state_d = RUN;
                    dir_d   = tgt_dir_q;
                end else if (tick) begin
                    dead_d = dead_q - DEAD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from next-state values so they register in
        // step with duty_cycle.
        eff_d    = tgt_en_d ? tgt_duty_d : 8'd0;
        ready_d  = (state_d == IDLE) || (state_d == RUN);
        busy_d   = (state_d != IDLE);
        enable_d = ((state_d == RUN) || (state_d == REV_DOWN)) && (duty_d != 8'd0);
        at_tgt_d = ready_d && (duty_d == eff_d) && ((dir_d == tgt_dir_d) || (eff_d == 8'd0));
    end

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            duty_q     <= 8'd0;
            dir_q      <= 1'b1;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            at_tgt_q   <= 1'b1;
            tgt_duty_q <= 8'd0;
            tgt_dir_q  <= 1'b1;
            tgt_en_q   <= 1'b0;
            presc_q    <= '0;
            dead_q     <= '0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            enable_q   <= enable_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            at_tgt_q   <= at_tgt_d;
            tgt_duty_q <= tgt_duty_d;
            tgt_dir_q  <= tgt_dir_d;
            tgt_en_q   <= tgt_en_d;
            presc_q    <= presc_d;
            dead_q     <= dead_d;
        end
    end

`ifdef MOTOR_RAMP_WDT_EN
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt_q  <= '0;
            wdt_trip_q <= 1'b0;
        end else begin
            wdt_cnt_q  <= wdt_cnt_d;
            wdt_trip_q <= wdt_trip_d;
        end
    end
    assign wdt_trip = wdt_trip_q;
`else
    assign wdt_trip = 1'b0;
`endif

    assign duty_cycle = duty_q;
    assign dir        = dir_q;
    assign enable     = enable_q;
    assign busy       = busy_q;
    assign cmd_ready  = ready_q;
    assign at_target  = at_tgt_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
module tb_motor_ramp_ctrl;

    logic       cin = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_en = 1'b0;
    logic       cmd_dir = 1'b0;
    logic [7:0] cmd_duty = 8'd0;
    logic       cmd_ready;
    logic [7:0] duty_cycle;
    logic       dir, enable, busy, at_target, wdt_trip;

    int n_checks = 0;
    int n_pass   = 0;

    motor_ramp_ctrl #(
        .RAMP_DIV  (4),
        .RAMP_STEP (16),
        .DEAD_TICKS(2),
        .PRESC_W   (16),
        .WDT_TICKS (8)
    ) dut (
        .cin       (cin),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_en    (cmd_en),
        .cmd_dir   (cmd_dir),
        .cmd_duty  (cmd_duty),
        .duty_cycle(duty_cycle),
        .dir       (dir),
        .enable    (enable),
        .busy      (busy),
        .at_target (at_target),
        .wdt_trip  (wdt_trip)
    );

    always #5 cin = ~cin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic send(input logic en, input logic d, input logic [7:0] du);
        int n = 0;
        @(negedge cin);
        while (!cmd_ready && n < 200) begin
            @(negedge cin);
            n++;
        end
        check("send_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_en    = en;
        cmd_dir   = d;
        cmd_duty  = du;
        @(negedge cin);
        cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for the next change of duty_cycle.
    task automatic next_duty(output logic [7:0] v, output int cyc);
        logic [7:0] prev;
        prev = duty_cycle;
        cyc  = 0;
        do begin
            @(negedge cin);
            cyc++;
        end while (duty_cycle == prev && cyc < 100);
        v = duty_cycle;
    endtask

    task automatic wait_duty(input logic [7:0] target, input string tag);
        int n = 0;
        while (duty_cycle != target && n < 400) begin
            @(negedge cin);
            n++;
        end
        check(tag, duty_cycle, target);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 400) begin
            @(negedge cin);
            n++;
        end
        check(tag, busy, 0);
    endtask

    logic [7:0] exp_up1  [7] = '{8'd16, 8'd32, 8'd48, 8'd64, 8'd80, 8'd96, 8'd100};
    logic [7:0] exp_dn2a [3] = '{8'd84, 8'd68, 8'd64};
    logic [7:0] exp_dn2b [4] = '{8'd48, 8'd32, 8'd16, 8'd0};
    logic [7:0] exp_up2  [4] = '{8'd16, 8'd32, 8'd48, 8'd64};
    logic [7:0] exp_dn3  [4] = '{8'd48, 8'd32, 8'd16, 8'd10};

    initial begin
        logic [7:0] v;
        int         c;

        repeat (3) @(negedge cin);
        check("rst_duty", duty_cycle, 0);
        check("rst_dir", dir, 1);
        check("rst_enable", enable, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_at_target", at_target, 1);
        check("rst_wdt", wdt_trip, 0);
        rst_n = 1'b1;

`ifndef MOTOR_RAMP_WDT_EN
        // Ramp up to 100.
        send(1'b1, 1'b1, 8'd100);
        @(negedge cin);
        check("t1_busy", busy, 1);
        check("t1_at_target_low", at_target, 0);
        for (int i = 0; i < 7; i++) begin
            next_duty(v, c);
            check("t1_duty", v, exp_up1[i]);
            if (i > 0) check("t1_spacing", c, 4);
        end
        check("t1_at_target", at_target, 1);
        check("t1_enable", enable, 1);
        repeat (12) @(negedge cin);
        check("t1_hold", duty_cycle, 100);

        // Down to 64, then reverse.
        send(1'b1, 1'b1, 8'd64);
        for (int i = 0; i < 3; i++) begin
            next_duty(v, c);
            check("t2_pre_duty", v, exp_dn2a[i]);
        end
        check("t2_pre_at_target", at_target, 1);
        send(1'b1, 1'b0, 8'd64);
        for (int i = 0; i < 4; i++) begin
            next_duty(v, c);
            check("t2_down_duty", v, exp_dn2b[i]);
            if (i == 0) check("t2_ready_low", cmd_ready, 0);
            if (i == 0) check("t2_at_target_low", at_target, 0);
            check("t2_dir_held", dir, 1);
        end
        check("t2_enable_zero", enable, 0);
        c = 0;
        while (dir !== 1'b0 && c < 100) begin
            @(negedge cin);
            c++;
        end
        check("t2_dead_cycles", c, 9);
        check("t2_duty_at_flip", duty_cycle, 0);
        check("t2_ready_run", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            next_duty(v, c);
            check("t2_up_duty", v, exp_up2[i]);
            check("t2_up_spacing", c, (i == 0) ? 3 : 4);
        end
        check("t2_dir", dir, 0);
        check("t2_at_target", at_target, 1);

        // Down to 10, then stop.
        send(1'b1, 1'b0, 8'd10);
        for (int i = 0; i < 4; i++) begin
            next_duty(v, c);
            check("t3_duty", v, exp_dn3[i]);
        end
        send(1'b0, 1'b0, 8'd10);
        next_duty(v, c);
        check("t3_stop_duty", v, 0);
        wait_idle("t3_idle");
        check("t3_enable", enable, 0);
        check("t3_ready", cmd_ready, 1);
        check("t3_at_target", at_target, 1);

        // Upper clamp.
        send(1'b1, 1'b1, 8'd250);
        wait_duty(8'd250, "t4_reach_250");
        check("t4_dir", dir, 1);
        check("t4_at_target", at_target, 1);
        send(1'b1, 1'b1, 8'd255);
        next_duty(v, c);
        check("t4_duty_255", v, 255);
        check("t4_enable", enable, 1);

        // Reset in REV_DOWN at 32.
        send(1'b1, 1'b1, 8'd64);
        wait_duty(8'd64, "t5_reach_64");
        send(1'b1, 1'b0, 8'd64);
        next_duty(v, c);
        check("t5_duty_48", v, 48);
        next_duty(v, c);
        check("t5_duty_32", v, 32);
        check("t5_ready_low", cmd_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_duty", duty_cycle, 0);
        check("t5_enable", enable, 0);
        check("t5_dir", dir, 1);
        check("t5_ready", cmd_ready, 1);
        check("t5_busy", busy, 0);
        check("t5_at_target", at_target, 1);
        @(negedge cin);
        rst_n = 1'b1;

        // No watchdog: duty holds.
        send(1'b1, 1'b1, 8'd64);
        wait_duty(8'd64, "t6_reach_64");
        repeat (60) @(negedge cin);
        check("t6_wdt", wdt_trip, 0);
        check("t6_hold", duty_cycle, 64);
        check("t6_busy", busy, 1);
`else
        // Watchdog trips 8 ticks after the last accept and stops the motor.
        send(1'b1, 1'b1, 8'd64);
        wait_duty(8'd64, "t6_reach_64");
        check("t6_wdt_early", wdt_trip, 0);
        c = 0;
        while (!wdt_trip && c < 200) begin
            @(negedge cin);
            c++;
        end
        check("t6_wdt_trip", wdt_trip, 1);
        check("t6_duty_at_trip", duty_cycle, 64);
        wait_idle("t6_idle");
        check("t6_duty_zero", duty_cycle, 0);
        check("t6_enable", enable, 0);
        check("t6_wdt_sticky", wdt_trip, 1);
        send(1'b1, 1'b1, 8'd32);
        check("t6_wdt_clear", wdt_trip, 0);
        next_duty(v, c);
        check("t6_restart", v, 16);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
- Sequencer in front of the motor PWM stage. Accepts speed/direction commands over a valid/ready handshake.
- Drives `duty_cycle`, `dir` and `enable` to the PWM block. Duty is ramped in fixed steps at a prescaled tick rate.
- On a direction change, duty ramps to zero, a dead time is held, `dir` flips, then duty ramps back up. `dir` never toggles while current may be flowing.

Parameters:
- RAMP_DIV, 1000: clock cycles per ramp tick (must be ≥1).
- RAMP_STEP, 4: duty change per ramp tick (1..255).
- DEAD_TICKS, 8: ramp ticks held at zero duty during a reversal.
- PRESC_W, 16: prescaler counter width; must hold RAMP_DIV-1.
- WDT_TICKS, 256: watchdog timeout in ramp ticks (used only with the optional feature).

Ports:
- cin  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted
- cmd_en  in  1  1 = run, 0 = stop (target duty forced to 0)
- cmd_dir  in  1  1 forward, 0 backward
- cmd_duty  in  8  target duty
- duty_cycle  out  8  to PWM block
- dir  out  1  to PWM block
- enable  out  1  to PWM block
- busy  out  1  state != IDLE
- at_target  out  1  duty and dir equal the effective target, no reversal pending
- wdt_trip  out  1  watchdog fired (sticky)

Behaviour:
- Clock and reset: single clock `cin`. Reset is asynchronous, active-low on `rst_n`. All outputs are registered.
- Reset values:
  - state=IDLE, duty_cycle=0, dir=1, enable=0, busy=0
  - cmd_ready=1, at_target=1, wdt_trip=0
  - internal target registers: tgt_duty=0, tgt_dir=1, tgt_en=0; prescaler=0; dead counter=0
- Reset mid-operation forces the reset values immediately, including enable=0.
- Prescaler: free-running 0..RAMP_DIV-1. `tick` is a 1-cycle pulse when the count equals RAMP_DIV-1. RAMP_DIV=1 gives a tick every cycle.
- Accept: `cmd_valid & cmd_ready` at a rising edge latches cmd_en, cmd_dir and cmd_duty into the target registers. The new target takes effect from the next cycle. A tick in the same cycle uses the old target.
- Effective target `eff = tgt_en ? tgt_duty : 0`.
- `cmd_ready` = 1 in IDLE and RUN, 0 in REV_DOWN and DEAD.
- State IDLE:
  - duty=0, enable=0.
  - Next cycle after an accept with cmd_en=1 and cmd_duty>0: dir=cmd_dir, go to RUN.
  - Otherwise stay in IDLE; dir is unchanged.
- State RUN, on each tick:
  - duty<eff: duty = min(duty+RAMP_STEP, eff).
  - duty>eff: duty = max(duty-RAMP_STEP, eff).
  - Arithmetic is 9-bit with clamp; no 8-bit wrap or underflow.
- RUN exits and direction handling:
  - duty==0 and eff==0 in any cycle: next state IDLE.
  - tgt_dir!=dir and duty>0: next state REV_DOWN.
  - tgt_dir!=dir and duty==0: dir=tgt_dir, stay in RUN, no dead time.
- State REV_DOWN:
  - On each tick, duty = max(duty-RAMP_STEP, 0).
  - When duty reaches 0: load dead counter=DEAD_TICKS, go to DEAD.
- State DEAD:
  - duty=0, enable=0.
  - Each tick decrements the dead counter.
  - Counter==0: dir=tgt_dir, go to RUN. DEAD_TICKS=0 gives one cycle in DEAD.
- enable = 1 only in RUN or REV_DOWN with duty_cycle!=0. Registered with the same timing as duty_cycle.
- at_target = (state is IDLE or RUN) & duty_cycle==eff & (dir==tgt_dir | eff==0).
- busy = (state != IDLE).

Optional Feature:
- Macro: MOTOR_RAMP_WDT_EN.
- Defined:
  - A tick counter clears on every accept and on reset, and saturates at WDT_TICKS.
  - When it reaches WDT_TICKS: tgt_en forced to 0, so the block ramps to stop; wdt_trip set to 1.
  - wdt_trip stays set until the next accepted command, which clears it and the counter.
  - The watchdog is counting only in RUN, REV_DOWN and DEAD.
- Not defined: no counter; wdt_trip is tied to 0.

Test Plan:
(All scenarios use RAMP_DIV=4, RAMP_STEP=16, DEAD_TICKS=2.)
1. Ramp up: from IDLE, command en=1 dir=1 duty=100.
   -> busy=1; duty 16,32,48,64,80,96,100 on successive ticks, 4 cycles apart.
   -> at_target=1 after 100; duty never exceeds 100.
2. Reversal: at duty=64 dir=1, command dir=0 duty=64.
   -> cmd_ready=0; duty 48,32,16,0; enable=0 at 0.
   -> 2 ticks in DEAD; dir=0; ramps to 64; cmd_ready=1 from RUN entry.
3. Stop and clamp, part one: at duty=10, command en=0.
   -> next tick duty=0 (no underflow), then IDLE; busy=0, enable=0.
4. Stop and clamp, part two: at duty=250, command duty=255.
   -> next tick duty=255 (no wrap).
5. Reset mid-run: assert rst_n=0 during REV_DOWN at duty=32.
   -> same cycle duty=0, enable=0, dir=1, cmd_ready=1, state=IDLE.
6. Watchdog (macro defined, WDT_TICKS=8): command duty=64, then no commands.
   -> after 8 ticks wdt_trip=1 and duty ramps to 0, reaching IDLE.
   -> next accepted command clears wdt_trip.
   -> Macro undefined: wdt_trip stays 0 and duty holds 64.
